// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core load/store port (C)
// and a debug/loader port (D). Round-robin between the two ports, plus a
// D-side lock for multi-beat bursts. core_stall freezes the core while C waits.
// Optional feature: define ARB_TIMEOUT_EN to bound a D lock to MAX_LOCK cycles
// in LOCK_D. A forced release pulses d_err. Without the macro the lock is
// unbounded and d_err is tied low.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic [DATA_W-1:0] c_rdata,
  output logic              core_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  typedef enum logic {ARB = 1'b0, LOCK_D = 1'b1} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t   state;
  logic     last_d;    // 1: D held the most recent grant, so C wins the next tie
  logic     c_win;
  logic     d_win;
  logic     lock_ok;   // D may enter LOCK_D on this grant
  logic     timeout;   // lock forcibly released on this edge
  mem_req_t c_rq;
  mem_req_t d_rq;
  mem_req_t sel_rq;

  assign c_rq = {c_we, c_addr, c_wdata};
  assign d_rq = {d_we, d_addr, d_wdata};

  // Grant decision. Every grant is forced low while reset is asserted.
  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (rst_n) begin
      if (state == LOCK_D) begin
        d_win = d_req;
      end else if (c_req && d_req) begin
        c_win = last_d;
        d_win = ~last_d;
      end else begin
        c_win = c_req;
        d_win = d_req;
      end
    end
  end

  // Memory-side mux. The idle cycle drives all zeros, so there is no strobe.
  always_comb begin
    sel_rq = '0;
    if (c_win)      sel_rq = c_rq;
    else if (d_win) sel_rq = d_rq;
  end

  assign c_gnt      = c_win;
  assign d_gnt      = d_win;
  assign core_stall = c_req & ~c_win;
  assign c_rdata    = mem_rdata;
  assign mem_addr   = sel_rq.addr;
  assign mem_wdata  = sel_rq.wdata;
  assign mem_we     = sel_rq.we;
  assign mem_re     = (c_win | d_win) & ~sel_rq.we;

`ifdef ARB_TIMEOUT_EN
  localparam int LCW = $clog2(MAX_LOCK);

  logic [LCW-1:0] lock_cnt;
  logic           relock_blk;  // set by a forced release, cleared once d_lock drops
  logic           d_err_q;

  assign timeout = (state == LOCK_D) && d_req && d_lock &&
                   (lock_cnt == LCW'(MAX_LOCK - 1));
  assign lock_ok = ~relock_blk;
  assign d_err   = d_err_q;

  // Lock watchdog: count the cycles spent in LOCK_D and block any re-lock after a forced release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt   <= '0;
      relock_blk <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      d_err_q <= timeout;
      if (state == LOCK_D) lock_cnt <= lock_cnt + 1'b1;
      else                 lock_cnt <= '0;
      if (timeout)      relock_blk <= 1'b1;
      else if (!d_lock) relock_blk <= 1'b0;
    end
  end
`else
  logic lock_unused;

  assign timeout     = 1'b0;
  assign lock_ok     = 1'b1;
  assign d_err       = 1'b0;
  assign lock_unused = (MAX_LOCK < 2);
`endif

  // Arbiter FSM: round-robin in ARB, exclusive D ownership in LOCK_D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB;
      last_d <= 1'b1;
    end else begin
      case (state)
        ARB: begin
          if (c_win) begin
            last_d <= 1'b0;
          end else if (d_win) begin
            last_d <= 1'b1;
            if (d_lock && lock_ok) state <= LOCK_D;
          end
        end
        LOCK_D: begin
          last_d <= 1'b1;
          if (timeout || !d_lock || !d_req) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  // Debug read response: capture the data on the grant edge and flag it for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= d_win & ~d_we;
      if (d_win && !d_we) d_rdata <= mem_rdata;
    end
  end

  // Core stall counter. It saturates and does not wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  stall_cnt <= '0;
    else if (core_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

endmodule
